// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 pixel timing: scan counters, blank, delayed syncs, frame pulse/counter
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [5:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
        end
    endgenerate

    // Decode bounds are 11 bits wide because a sync end may sit exactly at 1024.
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_L = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_L = 11'(V_VISIBLE);
    localparam logic [10:0] H_SS    = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SE    = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_SS    = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SE    = 11'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic        running;
    logic [10:0] hc_ext, vc_ext;
    logic        hs_raw, vs_raw, hs_in, vs_in;

    assign running = (state_q == ST_RUN);

    always_comb begin
        hc_d        = hc_q;
        vc_d        = vc_q;
        frame_cnt_d = frame_cnt_q;
        if (running) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d        = '0;
                    frame_cnt_d = frame_cnt_q + 6'd1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hc_q        <= '0;
            vc_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= ST_RUN;
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hc_ext = {1'b0, hc_q};
    assign vc_ext = {1'b0, vc_q};

    assign blank       = running & (hc_ext < H_VIS_L) & (vc_ext < V_VIS_L);
    assign frame_start = running & (hc_q == 10'd0) & (vc_q == 10'd0);
    assign hs_raw      = ~((hc_ext >= H_SS) && (hc_ext < H_SE));
    assign vs_raw      = ~((vc_ext >= V_SS) && (vc_ext < V_SE));

    // Syncs are held inactive until the counters are actually running.
    assign hs_in = hs_raw | ~running;
    assign vs_in = vs_raw | ~running;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = hs_in;
            assign vs = vs_in;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_sr_q;
            logic [SYNC_DELAY-1:0] vs_sr_q;

            always_ff @(posedge vga_clk) begin
                if (!reset_n) begin
                    hs_sr_q <= '1;
                    vs_sr_q <= '1;
                end else begin
                    hs_sr_q[0] <= hs_in;
                    vs_sr_q[0] <= vs_in;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_sr_q[i] <= hs_sr_q[i-1];
                        vs_sr_q[i] <= vs_sr_q[i-1];
                    end
                end
            end

            assign hs = hs_sr_q[SYNC_DELAY-1];
            assign vs = vs_sr_q[SYNC_DELAY-1];
        end
    endgenerate

    assign DrawX     = hc_q;
    assign DrawY     = vc_q;
    assign frame_cnt = frame_cnt_q;

endmodule
